// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory responder: RISC-V width codes,
// responder FSM states and access legality helpers.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Stores only have B/H/W; loads add the unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: return a[0];
      F3_W:        return a != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Two-port round-robin arbiter; on a tie the port not granted last wins.
module dmem_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_accept,
  output logic o_grant0,
  output logic o_grant1
);

  logic r_last_grant;

  assign o_grant0 = i_valid0 && (!i_valid1 || r_last_grant);
  assign o_grant1 = i_valid1 && (!i_valid0 || !r_last_grant);

  // Reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last_grant <= 1'b1;
    else if (i_accept) r_last_grant <= o_grant1;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: arbitrates two requesters, performs byte/half/word
// accesses after a programmable wait and returns one registered response.
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [2:0]  req0_funct3,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [2:0]  req1_funct3,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp_valid,
  output logic        rsp_port,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t      r_state, w_next;
  logic [2:0]  r_cnt;
  logic        r_port, r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_grant0, w_grant1, w_accept, w_done;
  logic        w_oob, w_err, w_mem_we;
  logic [AW-1:0] w_idx;
  logic [31:0] w_word, w_load, w_wal;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be;

  dmem_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_accept (w_accept),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1)
  );

  assign req0_ready = (r_state == ST_IDLE) && w_grant0;
  assign req1_ready = (r_state == ST_IDLE) && w_grant1;
  assign w_accept   = req0_ready || req1_ready;
  assign w_done     = (r_state == ST_WAIT) && (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_WAIT;
      ST_WAIT: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_cnt   <= 3'(LATENCY);
      r_port  <= w_grant1;
      r_we    <= w_grant1 ? req1_we     : req0_we;
      r_f3    <= w_grant1 ? req1_funct3 : req0_funct3;
      r_addr  <= w_grant1 ? req1_addr   : req0_addr;
      r_wdata <= w_grant1 ? req1_wdata  : req0_wdata;
    end else if (r_state == ST_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  assign w_idx  = r_addr[AW+1:2];
  assign w_oob  = {2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign w_err  = !f3_legal(r_we, r_f3) || f3_misaligned(r_f3, r_addr[1:0]) || w_oob;
  assign w_word = r_mem[w_idx];
  assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  always_comb begin
    w_load = '0;
    case (r_f3)
      F3_B:    w_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    w_load = {{16{w_half[15]}}, w_half};
      F3_W:    w_load = w_word;
      F3_BU:   w_load = {24'd0, w_byte};
      F3_HU:   w_load = {16'd0, w_half};
      default: w_load = '0;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the lanes.
  always_comb begin
    w_be  = '0;
    w_wal = '0;
    case (r_f3)
      F3_B: begin
        w_be[r_addr[1:0]] = 1'b1;
        w_wal = {4{r_wdata[7:0]}};
      end
      F3_H: begin
        w_be  = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wal = {2{r_wdata[15:0]}};
      end
      F3_W: begin
        w_be  = '1;
        w_wal = r_wdata;
      end
      default: begin
        w_be  = '0;
        w_wal = '0;
      end
    endcase
  end

  assign w_mem_we = w_done && r_we && !w_err && !rst;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wal[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_port  <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (w_done) begin
      rsp_valid <= 1'b1;
      rsp_port  <= r_port;
      rsp_rdata <= (w_err || r_we) ? '0 : w_load;
      rsp_err   <= w_err;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A uses LATENCY=1, instance B
// uses LATENCY=3 for the mid-operation reset case.
module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, v0, v1;
  logic        we0, we1;
  logic [2:0]  f30, f31;
  logic [31:0] a0, a1, wd0, wd1;
  logic [1:0]  rdy0, rdy1, rv, rp, re;
  logic [31:0] rdat_a, rdat_b;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_a (
    .clk(clk), .rst(rst[0]),
    .req0_valid(v0[0]), .req0_ready(rdy0[0]), .req0_we(we0), .req0_funct3(f30),
    .req0_addr(a0), .req0_wdata(wd0),
    .req1_valid(v1[0]), .req1_ready(rdy1[0]), .req1_we(we1), .req1_funct3(f31),
    .req1_addr(a1), .req1_wdata(wd1),
    .rsp_valid(rv[0]), .rsp_port(rp[0]), .rsp_rdata(rdat_a), .rsp_err(re[0])
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(3)) u_b (
    .clk(clk), .rst(rst[1]),
    .req0_valid(v0[1]), .req0_ready(rdy0[1]), .req0_we(we0), .req0_funct3(f30),
    .req0_addr(a0), .req0_wdata(wd0),
    .req1_valid(v1[1]), .req1_ready(rdy1[1]), .req1_we(we1), .req1_funct3(f31),
    .req1_addr(a1), .req1_wdata(wd1),
    .rsp_valid(rv[1]), .rsp_port(rp[1]), .rsp_rdata(rdat_b), .rsp_err(re[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int d, input int p);
    return (p == 0) ? rdy0[d] : rdy1[d];
  endfunction

  // Issue one request, wait for its response, check latency and strobe width.
  task automatic do_req(input int d, input int p, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                        output logic [31:0] rd, output logic er, output logic rpo);
    int n;
    if (p == 0) begin we0 = we; f30 = f3; a0 = addr; wd0 = wdata; v0[d] = 1'b1; end
    else        begin we1 = we; f31 = f3; a1 = addr; wd1 = wdata; v1[d] = 1'b1; end
    #1;
    n = 0;
    while (!rdy(d, p) && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, " ready"}, 32'(rdy(d, p)), 32'd1);
    @(posedge clk); #1;
    v0[d] = 1'b0; v1[d] = 1'b0;
    n = 0;
    while (!rv[d] && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, " latency"}, 32'(n), (d == 0) ? 32'd2 : 32'd4);
    rd  = (d == 0) ? rdat_a : rdat_b;
    er  = re[d];
    rpo = rp[d];
    @(posedge clk); #1;
    chk({tag, " strobe"}, 32'(rv[d]), 32'd0);
  endtask

  task automatic ld(input int d, input int p, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] exp, input logic experr, input string tag);
    logic [31:0] rd; logic er, rpo;
    do_req(d, p, 1'b0, f3, addr, 32'd0, tag, rd, er, rpo);
    chk({tag, " rdata"}, rd, exp);
    chk({tag, " err"}, 32'(er), 32'(experr));
    chk({tag, " port"}, 32'(rpo), 32'(p));
  endtask

  task automatic st(input int d, input int p, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic experr, input string tag);
    logic [31:0] rd; logic er, rpo;
    do_req(d, p, 1'b1, f3, addr, wdata, tag, rd, er, rpo);
    chk({tag, " rdata"}, rd, 32'd0);
    chk({tag, " err"}, 32'(er), 32'(experr));
  endtask

  initial begin
    int acc[$];
    int rsq[$];
    int seen;
    rst = 2'b11; v0 = '0; v1 = '0;
    we0 = 0; we1 = 0; f30 = 3'b010; f31 = 3'b010; a0 = 0; a1 = 0; wd0 = 0; wd1 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 2'b00;
    #1;
    chk("reset rsp_valid", 32'(rv[0]), 32'd0);
    chk("reset rsp_port", 32'(rp[0]), 32'd0);
    chk("reset rsp_rdata", rdat_a, 32'd0);
    chk("reset rsp_err", 32'(re[0]), 32'd0);
    v0[0] = 1'b1; v1[0] = 1'b1;
    #1;
    chk("reset tie ready0", 32'(rdy0[0]), 32'd1);
    chk("reset tie ready1", 32'(rdy1[0]), 32'd0);
    v0[0] = 1'b0; v1[0] = 1'b0;
    @(posedge clk); #1;

    st(0, 0, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, "sw10");
    ld(0, 0, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, "lw10");

    st(0, 0, 3'b010, 32'h20, 32'h80FF7F01, 1'b0, "sw20");
    ld(0, 0, 3'b000, 32'h23, 32'hFFFFFF80, 1'b0, "lb23");
    ld(0, 0, 3'b100, 32'h23, 32'h00000080, 1'b0, "lbu23");
    ld(0, 0, 3'b001, 32'h22, 32'hFFFF80FF, 1'b0, "lh22");
    ld(0, 0, 3'b101, 32'h20, 32'h00007F01, 1'b0, "lhu20");

    st(0, 0, 3'b010, 32'h30, 32'h11223344, 1'b0, "sw30");
    st(0, 0, 3'b000, 32'h31, 32'h000000AA, 1'b0, "sb31");
    ld(0, 0, 3'b010, 32'h30, 32'h1122AA44, 1'b0, "lw30");
    st(0, 1, 3'b001, 32'h36, 32'h0000BEEF, 1'b0, "p1 sh36");
    ld(0, 1, 3'b010, 32'h34, 32'hBEEF0000, 1'b0, "p1 lw34");

    st(0, 0, 3'b010, 32'h0, 32'h5555AAAA, 1'b0, "sw0");
    ld(0, 0, 3'b010, 32'h13, 32'h0, 1'b1, "err lw13");
    ld(0, 0, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, "after lw13");
    st(0, 0, 3'b001, 32'h21, 32'h0000FFFF, 1'b1, "err sh21");
    ld(0, 0, 3'b010, 32'h20, 32'h80FF7F01, 1'b0, "after sh21");
    st(0, 0, 3'b011, 32'h30, 32'h0, 1'b1, "err f3 011");
    ld(0, 0, 3'b010, 32'h30, 32'h1122AA44, 1'b0, "after f3 011");
    st(0, 0, 3'b010, 32'h1000, 32'h12345678, 1'b1, "err oob");
    ld(0, 0, 3'b010, 32'h0, 32'h5555AAAA, 1'b0, "after oob");

    // Port 1 goes last so port 0 wins the next tie.
    ld(0, 1, 3'b010, 32'h20, 32'h80FF7F01, 1'b0, "p1 lw20");
    we0 = 0; f30 = 3'b010; a0 = 32'h10;
    we1 = 0; f31 = 3'b010; a1 = 32'h20;
    v0[0] = 1'b1; v1[0] = 1'b1;
    #1;
    for (int n = 0; n < 60 && rsq.size() < 4; n++) begin
      if (rv[0]) begin
        rsq.push_back(int'(rp[0]));
        chk("arb rdata", rdat_a, rp[0] ? 32'h80FF7F01 : 32'hDEADBEEF);
      end
      if (acc.size() < 4) begin
        if (rdy0[0]) acc.push_back(0);
        else if (rdy1[0]) acc.push_back(1);
      end else begin
        v0[0] = 1'b0; v1[0] = 1'b0;
      end
      @(posedge clk); #1;
    end
    v0[0] = 1'b0; v1[0] = 1'b0;
    chk("arb accepts", 32'(acc.size()), 32'd4);
    chk("arb responses", 32'(rsq.size()), 32'd4);
    for (int i = 0; i < acc.size(); i++) chk("arb accept order", 32'(acc[i]), 32'(i % 2));
    for (int i = 0; i < rsq.size(); i++) chk("arb rsp_port order", 32'(rsq[i]), 32'(i % 2));
    @(posedge clk); #1;

    st(1, 0, 3'b010, 32'h40, 32'h12345678, 1'b0, "b sw40");
    we0 = 1; f30 = 3'b010; a0 = 32'h40; wd0 = 32'hCAFEF00D; v0[1] = 1'b1;
    #1;
    chk("b abort ready", 32'(rdy0[1]), 32'd1);
    @(posedge clk); #1;
    v0[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      if (n == 2) rst[1] = 1'b0;
      if (rv[1]) seen++;
      @(posedge clk); #1;
    end
    chk("b abort no rsp", 32'(seen), 32'd0);
    ld(1, 0, 3'b010, 32'h40, 32'h12345678, 1'b0, "b lw40 old");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32IF pipeline. It accepts load/store requests from two requesters: the integer MEM stage on port 0 and the FP load/store path (flw/fsw) on port 1. Round-robin arbitration picks one request at a time. The block performs byte/half/word accesses with sign or zero extension and returns one registered response per accepted request after a programmable wait latency. It replaces direct combinational memory access, so the pipeline can tolerate slow memory.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 1, extra wait cycles before the access; legal range 0..7.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid, req1_valid  in  1  request present on port 0 (integer) / port 1 (FP).
- req0_ready, req1_ready  out  1  request accepted this cycle when valid && ready.
- reqN_we  in  1  1 = store, 0 = load (one per port).
- reqN_funct3  in  3  RISC-V width code (one per port).
- reqN_addr  in  32  byte address (one per port).
- reqN_wdata  in  32  store data, right-aligned (one per port).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_port  out  1  port the response belongs to.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access, illegal funct3, or out-of-range address.

## Operation
- FSM states:
  - IDLE: readies are driven from the arbiter.
  - On accept, go to WAIT and load cnt = LATENCY. Latch port, we, funct3, addr, wdata.
  - WAIT: if cnt != 0, decrement. If cnt == 0, perform the access, register the response, and go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE.
- Arbitration:
  - reqN_ready = (state == IDLE) && grantN.
  - Only one valid: that port is granted.
  - Both valid: grant the port not granted last. last_grant updates on accept only.
  - No request is accepted outside IDLE.
- Loads:
  - funct3 000 LB (sign-extend byte), 001 LH (sign-extend half), 010 LW, 100 LBU, 101 LHU.
  - Byte lane is selected by addr[1:0]; half lane by addr[1]. Little-endian.
- Stores:
  - funct3 000 SB, 001 SH, 010 SW. Only the addressed byte lanes are written.
  - The write occurs on the same edge the response is registered.
- Errors:
  - Error conditions: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0; any other funct3; addr[31:2] >= DEPTH_WORDS.
  - Response: rsp_err = 1 and rsp_rdata = 0. Memory is not written.
- The response cannot be stalled; the consumer must take rsp_valid when it is high.

## Timing
- Accept in cycle T → rsp_valid high in cycle T+LATENCY+2.
- Earliest next accept is in cycle T+LATENCY+3, since ready is high again once the FSM is back in IDLE.
- Back-to-back throughput is one request per LATENCY+3 cycles.
- A load issued right after a store to the same word returns the new data, because the store is completed before IDLE.
- Reset values: state IDLE, rsp_valid 0, rsp_port 0, rsp_rdata 0, rsp_err 0, cnt 0, last_grant 1 (port 0 wins the first tie).
- Memory contents are not reset.
- rst asserted mid-operation aborts the request. A write not yet performed is never performed. No response is issued.
- req*_ready is combinational from state and valids. All rsp_* outputs are registered.

## Structure
- Shared package rv_mem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding (ST_IDLE, ST_WAIT, ST_RESP).
  - A width-code legality helper.
- One sub-module, dmem_rr_arbiter: a 2-port round-robin arbiter with a last_grant register, grant outputs, and an accept input.
- The memory array, lane write logic, and load extender stay in dmem_responder.

## Test plan
- LATENCY=1. Port 0 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rsp_rdata 0xDEADBEEF, rsp_err 0. Each response arrives 3 cycles after its accept.
- Word 0x20 = 0x80FF7F01. LB 0x23 → 0xFFFFFF80. LBU 0x23 → 0x00000080. LH 0x22 → 0xFFFF80FF. LHU 0x20 → 0x00007F01.
- SB 0x31 data 0xAA onto word 0x11223344, then LW 0x30 → 0x1122AA44.
- Both ports valid every cycle with loads → accepts alternate 0,1,0,1 and rsp_port follows the same order.
- Error cases: LW 0x13, SH 0x21, funct3 011, and addr 4*DEPTH_WORDS → each gives rsp_err 1, rsp_rdata 0. A following LW of the target word shows it unchanged.
- LATENCY=3. Assert rst one cycle after a SW accept → no rsp_valid is issued, and a later LW shows the old data.
